// File: rtl/enc_stream_fifo.sv
// Output stream buffer for the arithmetic encoder: packs variable-length bit groups
// into WORD_W-bit words, queues them in a circular RAM FIFO and serializes OUT_W-bit symbols.
module enc_stream_fifo #(
  parameter int IN_W      = 16,
  parameter int WORD_W    = 16,
  parameter int OUT_W     = 8,
  parameter int DEPTH     = 2048,
  parameter bit ZERO_FILL = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IN_W-1:0]         in_bits,
  input  logic [$clog2(IN_W):0]   in_count,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic                    flush_done,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic [31:0]             byte_count,
  output logic                    error
);

  localparam int CNT_W  = $clog2(IN_W) + 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int ACC_W  = 2 * WORD_W;
  localparam int FILL_W = $clog2(ACC_W) + 1;
  localparam int SYMS   = WORD_W / OUT_W;
  localparam int SYM_W  = $clog2(SYMS) + 1;
  localparam int BYTES  = WORD_W / 8;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PAD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [ACC_W-1:0] low_mask(input logic [FILL_W-1:0] n);
    logic [ACC_W-1:0] m;
    m = '0;
    for (int i = 0; i < ACC_W; i++) begin
      m[i] = (i < int'(n));
    end
    return m;
  endfunction

  state_t               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic                 drained_q, drained_d;
  logic                 error_q, error_d;
  logic                 flush_done_q, flush_done_d;
  logic [31:0]          byte_q, byte_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic                 rd_pend_q;
  logic [WORD_W-1:0]    rd_data_q;
  logic [WORD_W-1:0]    ser_word_q, ser_word_d;
  logic [SYM_W-1:0]     ser_left_q, ser_left_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_W-1:0]     out_data_q, out_data_d;
  logic [WORD_W-1:0]    mem_q [DEPTH];

  logic                 ready;
  logic                 accept;
  logic [CNT_W-1:0]     cnt_eff;
  logic [ACC_W-1:0]     masked;
  logic [ACC_W-1:0]     merged_acc;
  logic [FILL_W-1:0]    merged_fill;
  logic                 wr_en;
  logic [WORD_W-1:0]    wr_word;
  logic                 rd_en;
  logic [WORD_W-1:0]    src_word;
  logic [SYM_W-1:0]     src_left;
  logic                 out_take;
  logic                 zf;

  // Two free slots are required: the flush cycle and the following PAD cycle may each write a word.
  assign ready  = (state_q == ST_RUN) && (level_q <= LVL_W'(DEPTH - 2));
  assign accept = in_valid && ready;

  // Packer: append the accepted group, emit the oldest WORD_W bits once available, run flush FSM
  always_comb begin
    if (accept) begin
      if (in_count > CNT_W'(IN_W)) begin
        cnt_eff = CNT_W'(IN_W);
      end else begin
        cnt_eff = in_count;
      end
    end else begin
      cnt_eff = '0;
    end
    masked       = ACC_W'(in_bits) & low_mask(FILL_W'(cnt_eff));
    merged_acc   = (acc_q << cnt_eff) | masked;
    merged_fill  = fill_q + FILL_W'(cnt_eff);

    state_d      = state_q;
    acc_d        = acc_q;
    fill_d       = fill_q;
    wr_en        = 1'b0;
    wr_word      = '0;
    flush_done_d = 1'b0;
    drained_d    = drained_q;
    error_d      = error_q;

    case (state_q)
      ST_RUN: begin
        if (merged_fill >= FILL_W'(WORD_W)) begin
          wr_en   = 1'b1;
          wr_word = WORD_W'(merged_acc >> (merged_fill - FILL_W'(WORD_W)));
          fill_d  = merged_fill - FILL_W'(WORD_W);
          acc_d   = merged_acc & low_mask(merged_fill - FILL_W'(WORD_W));
        end else begin
          fill_d  = merged_fill;
          acc_d   = merged_acc;
        end
        if (accept && (in_count > CNT_W'(IN_W))) begin
          error_d = 1'b1;
        end else begin
          error_d = error_q;
        end
        if (accept && (cnt_eff != '0)) begin
          drained_d = 1'b0;
        end else begin
          drained_d = drained_q;
        end
        if (ready && flush) begin
          state_d = ST_PAD;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PAD: begin
        // Leftover bits go out left-justified with zero padding below them.
        if (fill_q != '0) begin
          wr_en   = 1'b1;
          wr_word = WORD_W'(acc_q << (FILL_W'(WORD_W) - fill_q));
        end else begin
          wr_en   = 1'b0;
        end
        fill_d       = '0;
        acc_d        = '0;
        flush_done_d = 1'b1;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        drained_d = 1'b1;
        state_d   = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Reader: serializer takes RAM data directly so a fresh word can feed the output the cycle it arrives
  always_comb begin
    if (rd_pend_q) begin
      src_word = rd_data_q;
      src_left = SYM_W'(SYMS);
    end else begin
      src_word = ser_word_q;
      src_left = ser_left_q;
    end
    out_take = !out_valid_q || out_ready;
    zf = ZERO_FILL && drained_q && (level_q == '0) && (src_left == '0) &&
         (fill_q == '0) && (state_q == ST_RUN);

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ser_word_d  = src_word;
    ser_left_d  = src_left;
    if (out_take) begin
      if (src_left != '0) begin
        out_valid_d = 1'b1;
        out_data_d  = src_word[WORD_W-1 -: OUT_W];
        ser_word_d  = src_word << OUT_W;
        ser_left_d  = src_left - SYM_W'(1);
      end else if (zf) begin
        out_valid_d = 1'b1;
        out_data_d  = '0;
      end else begin
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
      end
    end else begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
    end
    rd_en = (level_q != '0) && (ser_left_d == '0);
  end

  // FIFO bookkeeping: pointers, occupancy and byte counter
  always_comb begin
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      byte_d   = byte_q + 32'(BYTES);
    end else begin
      wr_ptr_d = wr_ptr_q;
      byte_d   = byte_q;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      acc_q        <= '0;
      fill_q       <= '0;
      drained_q    <= 1'b0;
      error_q      <= 1'b0;
      flush_done_q <= 1'b0;
      byte_q       <= 32'd0;
      level_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rd_pend_q    <= 1'b0;
      ser_word_q   <= '0;
      ser_left_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      drained_q    <= drained_d;
      error_q      <= error_d;
      flush_done_q <= flush_done_d;
      byte_q       <= byte_d;
      level_q      <= level_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_pend_q    <= rd_en;
      ser_word_q   <= ser_word_d;
      ser_left_q   <= ser_left_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  // Word RAM: one write port, one read port with a single cycle of latency
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_ptr_q];
    end
  end

  assign in_ready   = ready;
  assign flush_done = flush_done_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign level      = level_q;
  assign byte_count = byte_q;
  assign error      = error_q;

endmodule

// File: tb/tb_enc_stream_fifo.sv
// Scoreboard bench for enc_stream_fifo: a bit-queue reference model predicts the symbol
// stream; two DUT copies (zero-fill on/off) share the stimulus.
`timescale 1ns/1ps
module tb_enc_stream_fifo;

  localparam int IN_W   = 16;
  localparam int WORD_W = 16;
  localparam int OUT_W  = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(IN_W) + 1;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [IN_W-1:0]   in_bits = '0;
  logic [CNT_W-1:0]  in_count = '0;
  logic              in_valid = 1'b0;
  logic              flush = 1'b0;
  logic              out_ready = 1'b0;

  logic              in_ready_a, flush_done_a, out_valid_a, error_a;
  logic [OUT_W-1:0]  out_data_a;
  logic [LVL_W-1:0]  level_a;
  logic [31:0]       byte_count_a;
  logic              in_ready_b, flush_done_b, out_valid_b, error_b;
  logic [OUT_W-1:0]  out_data_b;
  logic [LVL_W-1:0]  level_b;
  logic [31:0]       byte_count_b;

  enc_stream_fifo #(.IN_W(IN_W), .WORD_W(WORD_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .ZERO_FILL(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_bits(in_bits), .in_count(in_count), .in_valid(in_valid),
    .in_ready(in_ready_a), .flush(flush), .flush_done(flush_done_a), .out_data(out_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .level(level_a), .byte_count(byte_count_a),
    .error(error_a));

  enc_stream_fifo #(.IN_W(IN_W), .WORD_W(WORD_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .ZERO_FILL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_bits(in_bits), .in_count(in_count), .in_valid(in_valid),
    .in_ready(in_ready_b), .flush(flush), .flush_done(flush_done_b), .out_data(out_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .level(level_b), .byte_count(byte_count_b),
    .error(error_b));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [OUT_W-1:0] exp_a[$];
  logic [OUT_W-1:0] exp_b[$];
  bit   bitq[$];
  int   words = 0;
  bit   zf_ok = 1'b0;
  int   flushes = 0;
  int   fd_cycles = 0;
  int   or_mode = 0;
  bit   stall_a = 1'b0;
  logic [OUT_W-1:0] held_a = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stream is a plain bit queue cut into words and symbols.
  task automatic emit_words(input bit pad);
    logic [WORD_W-1:0] w;
    logic [OUT_W-1:0]  sym;
    w = '0;
    if (pad && bitq.size() > 0) begin
      while (bitq.size() < WORD_W) bitq.push_back(1'b0);
    end
    while (bitq.size() >= WORD_W) begin
      for (int i = 0; i < WORD_W; i++) w = {w[WORD_W-2:0], bitq.pop_front()};
      words++;
      for (int s = 0; s < WORD_W / OUT_W; s++) begin
        sym = w[WORD_W-1-s*OUT_W -: OUT_W];
        exp_a.push_back(sym);
        exp_b.push_back(sym);
      end
    end
  endtask

  task automatic model_group(input logic [IN_W-1:0] bits, input int cnt);
    int n;
    n = (cnt > IN_W) ? IN_W : cnt;
    for (int i = n - 1; i >= 0; i--) bitq.push_back(bits[i]);
    if (n > 0) zf_ok = 1'b0;
    emit_words(1'b0);
  endtask

  task automatic model_flush();
    emit_words(1'b1);
    zf_ok = 1'b1;
    flushes++;
  endtask

  // One input cycle, entered and left at posedge+1; acceptance is judged mid-cycle.
  task automatic cycle(input logic v, input logic [IN_W-1:0] b, input int c, input logic f, output bit ok);
    in_valid = v;
    in_bits  = b;
    in_count = CNT_W'(c);
    flush    = f;
    @(negedge clk);
    ok = in_ready_a;
    if (in_ready_a) begin
      if (v) model_group(b, c);
      if (f) model_flush();
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic send(input logic v, input logic [IN_W-1:0] b, input int c, input logic f);
    bit ok;
    int tries;
    tries = 0;
    do begin
      cycle(v, b, c, f, ok);
      tries++;
    end while (!ok && tries < 200);
    check("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    @(posedge clk);
    #1;
    exp_a.delete();
    exp_b.delete();
    bitq.delete();
    zf_ok = 1'b0;
    words = 0;
    rst   = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready_a), 32'd1);
    check("rst_flush_done", 32'(flush_done_a), 32'd0);
    check("rst_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_out_data", 32'(out_data_a), 32'd0);
    check("rst_level", 32'(level_a), 32'd0);
    check("rst_byte_count", byte_count_a, 32'd0);
    check("rst_error", 32'(error_a), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((exp_a.size() > 0 || exp_b.size() > 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain_complete", 32'(exp_a.size() == 0 && exp_b.size() == 0), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_tail(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("zf_valid_a", 32'(out_valid_a), 32'd1);
      check("nozf_idle_b", 32'(out_valid_b), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  // out_ready driver: 0 = held low, 1 = held high, 2 = random
  initial forever begin
    @(posedge clk);
    #1;
    case (or_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 1) == 1);
    endcase
  end

  // Monitor for the zero-fill instance: scoreboard pop plus hold-while-stalled check
  always @(negedge clk) begin
    if (rst) begin
      stall_a = 1'b0;
    end else begin
      if (stall_a) begin
        check("hold_valid_a", 32'(out_valid_a), 32'd1);
        check("hold_data_a", 32'(out_data_a), 32'(held_a));
      end
      if (out_valid_a && out_ready) begin
        if (exp_a.size() > 0) begin
          check("sym_a", 32'(out_data_a), 32'(exp_a.pop_front()));
        end else if (zf_ok) begin
          check("zero_fill_a", 32'(out_data_a), 32'd0);
        end else begin
          checks++;
          errors++;
          $display("FAIL sym_a_unexpected: got %0h with nothing expected at %0t", out_data_a, $time);
        end
      end
      stall_a = out_valid_a && !out_ready;
      held_a  = out_data_a;
    end
  end

  // Monitor for the non-zero-fill instance
  always @(negedge clk) begin
    if (!rst && out_valid_b && out_ready) begin
      if (exp_b.size() > 0) begin
        check("sym_b", 32'(out_data_b), 32'(exp_b.pop_front()));
      end else begin
        checks++;
        errors++;
        $display("FAIL sym_b_unexpected: got %0h with nothing expected at %0t", out_data_b, $time);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && flush_done_a) fd_cycles++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    do_reset();

    // Two groups forming 0xBFFF, then a flush with nothing left to pad
    or_mode = 1;
    send(1'b1, 16'h0005, 3, 1'b0);
    cycle(1'b1, 16'h1FFF, 13, 1'b0, ok);
    check("grp2_accepted", 32'(ok), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    check("lat_level_n1", 32'(level_a), 32'd1);
    check("flush_ready", 32'(in_ready_a), 32'd1);
    if (in_ready_a) model_flush();
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("lat_valid_n2", 32'(out_valid_a), 32'd0);
    check("pad_in_ready", 32'(in_ready_a), 32'd0);
    check("pad_flush_done", 32'(flush_done_a), 32'd0);
    @(negedge clk);
    check("lat_valid_n3", 32'(out_valid_a), 32'd1);
    check("done_flush_done", 32'(flush_done_a), 32'd1);
    check("done_in_ready", 32'(in_ready_a), 32'd0);
    @(posedge clk);
    #1;
    wait_drain(50);
    check("t1_bytes", byte_count_a, 32'(words * 2));
    check("t1_words", 32'(words), 32'd1);
    check_zero_tail(6);
    check("t1_flush_done_cycles", 32'(fd_cycles), 32'(flushes));

    // Single bit padded out to 0x8000
    do_reset();
    or_mode = 1;
    send(1'b1, 16'h0001, 1, 1'b0);
    send(1'b0, 16'h0000, 0, 1'b1);
    wait_drain(50);
    check("t2_bytes", byte_count_a, 32'd2);
    check_zero_tail(6);
    check("t2_flush_done_cycles", 32'(fd_cycles), 32'(flushes));

    // Backpressure: fill the FIFO with output stalled
    do_reset();
    or_mode = 0;
    ok = 1'b1;
    for (int i = 0; i < 40 && ok; i++) begin
      cycle(1'b1, IN_W'($urandom), 16, 1'b0, ok);
    end
    check("bp_stalled", 32'(ok), 32'd0);
    check("bp_level", 32'(level_a), 32'(DEPTH - 1));
    check("bp_in_ready", 32'(in_ready_a), 32'd0);
    or_mode = 1;
    wait_drain(100);
    repeat (3) @(posedge clk);
    #1;
    check("bp_level_empty", 32'(level_a), 32'd0);
    check("bp_in_ready_back", 32'(in_ready_a), 32'd1);
    check("bp_bytes", byte_count_a, 32'(words * 2));
    check("bp_error_clear", 32'(error_a), 32'd0);
    check("bp_idle_a", 32'(out_valid_a), 32'd0);

    // Random groups with random stalls, pointer wrap and one oversize count
    do_reset();
    or_mode = 2;
    for (int i = 0; i < 60; i++) begin
      send(1'b1, IN_W'($urandom), (i == 20) ? 17 : int'($urandom_range(0, 16)), 1'b0);
    end
    send(1'b0, 16'h0000, 0, 1'b1);
    wait_drain(800);
    check("rnd_error_sticky", 32'(error_a), 32'd1);
    check("rnd_bytes", byte_count_a, 32'(words * 2));
    check("rnd_flush_done_cycles", 32'(fd_cycles), 32'(flushes));

    // Reset in the middle of a stream, then a fresh stream
    do_reset();
    or_mode = 0;
    for (int i = 0; i < 3; i++) send(1'b1, IN_W'($urandom), 16, 1'b0);
    send(1'b1, 16'h0015, 5, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("mid_level", 32'(level_a), 32'd2);
    do_reset();
    or_mode = 1;
    send(1'b1, 16'hABCD, 16, 1'b0);
    send(1'b0, 16'h0000, 0, 1'b1);
    wait_drain(50);
    check("post_rst_bytes", byte_count_a, 32'd2);
    check("post_rst_flush_done_cycles", 32'(fd_cycles), 32'(flushes));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
